// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational ALU between two requesters (0: core pipeline,
//   1: debug/UART command path) using round-robin arbitration and
//   valid/ready handshakes. An accepted request is registered, presented to
//   the ALU for exactly one cycle, and the captured result/zero flag are
//   returned on a single response channel tagged with the requester id.
//
// Ports
//   clk, rst_n                   clock (rising edge), async active-low reset
//   req_valid0/1, req_ready0/1   request handshake per requester
//   req_op0/1, req_sftmd0/1      ALUop and shift-mode flag per requester
//   req_a0/1, req_b0/1           operands per requester
//   alu_op/sftmd/a/b             drive the ALU; all-zero outside ISSUE
//   alu_result, alu_zero         combinational ALU outputs
//   rsp_valid, rsp_ready         response handshake
//   rsp_id, rsp_result, rsp_zero response owner, captured result and zero flag
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid0,
    output logic              req_ready0,
    input  logic [OP_W-1:0]   req_op0,
    input  logic              req_sftmd0,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic              req_valid1,
    output logic              req_ready1,
    input  logic [OP_W-1:0]   req_op1,
    input  logic              req_sftmd1,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    output logic [OP_W-1:0]   alu_op,
    output logic              alu_sftmd,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    logic   cur_id;
    logic   grant0;
    logic   grant1;

    // Under contention the requester that did not win last time is granted.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req_valid0 && req_valid1) begin
            grant0 = last_grant;
            grant1 = ~last_grant;
        end else begin
            grant0 = req_valid0;
            grant1 = req_valid1;
        end
    end

    assign req_ready0 = (state == IDLE) && grant0;
    assign req_ready1 = (state == IDLE) && grant1;

    // The alu_* registers double as the latched operands: loaded on accept,
    // cleared when ISSUE ends, so they are non-zero only during ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cur_id     <= 1'b0;
            alu_op     <= '0;
            alu_sftmd  <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        alu_op     <= grant1 ? req_op1    : req_op0;
                        alu_sftmd  <= grant1 ? req_sftmd1 : req_sftmd0;
                        alu_a      <= grant1 ? req_a1     : req_a0;
                        alu_b      <= grant1 ? req_b1     : req_b0;
                        cur_id     <= grant1;
                        last_grant <= grant1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    rsp_id     <= cur_id;
                    rsp_valid  <= 1'b1;
                    alu_op     <= '0;
                    alu_sftmd  <= 1'b0;
                    alu_a      <= '0;
                    alu_b      <= '0;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed table, hand-written
// contention/backpressure/reset sequences and randomized traffic checked
// against a behavioural round-robin/ALU model.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid0, req_ready0, req_sftmd0;
    logic [3:0]  req_op0;
    logic [31:0] req_a0, req_b0;
    logic        req_valid1, req_ready1, req_sftmd1;
    logic [3:0]  req_op1;
    logic [31:0] req_a1, req_b1;
    logic [3:0]  alu_op;
    logic        alu_sftmd;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_zero;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
    logic [31:0] rsp_result;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_W(32), .OP_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid0(req_valid0), .req_ready0(req_ready0), .req_op0(req_op0),
        .req_sftmd0(req_sftmd0), .req_a0(req_a0), .req_b0(req_b0),
        .req_valid1(req_valid1), .req_ready1(req_ready1), .req_op1(req_op1),
        .req_sftmd1(req_sftmd1), .req_a1(req_a1), .req_b1(req_b1),
        .alu_op(alu_op), .alu_sftmd(alu_sftmd), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero)
    );

    // ALU behaviour: returns {zero, result}.
    function automatic logic [32:0] alu_fn(input logic [3:0] op, input logic sm,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [4:0]  sh;
        sh = b[4:0];
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = sm ? (a << sh) : 32'd0;
            4'd6:    r = sm ? (a >> sh) : 32'd0;
            4'd7:    r = sm ? 32'($signed(a) >>> sh) : 32'd0;
            default: r = 32'd0;
        endcase
        return {(op == 4'd1) && (r == 32'd0), r};
    endfunction

    always_comb {alu_zero, alu_result} = alu_fn(alu_op, alu_sftmd, alu_a, alu_b);

    int total = 0;
    int bad   = 0;
    int model_last = 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Full transaction starting in IDLE with requests already driven.
    task automatic txn(input logic eid, input logic [31:0] ea, input logic [31:0] eres,
                       input logic ez, input int bp, input string tag);
        #1;
        chk({tag, ".ready0"}, req_ready0, eid == 1'b0);
        chk({tag, ".ready1"}, req_ready1, eid == 1'b1);
        @(posedge clk); #1;
        if (eid) req_valid1 = 1'b0; else req_valid0 = 1'b0;
        chk({tag, ".issue_a"}, alu_a, ea);
        chk({tag, ".issue_rdy"}, {req_ready1, req_ready0}, 2'b00);
        chk({tag, ".issue_vld"}, rsp_valid, 1'b0);
        @(posedge clk); #1;
        chk({tag, ".rsp"}, {rsp_valid, rsp_id, rsp_zero, rsp_result}, {1'b1, eid, ez, eres});
        chk({tag, ".alu_clr"}, {alu_op, alu_sftmd, alu_a, alu_b}, 69'd0);
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            chk({tag, ".hold"}, {rsp_valid, rsp_id, rsp_zero, rsp_result}, {1'b1, eid, ez, eres});
            chk({tag, ".hold_rdy"}, {req_ready1, req_ready0}, 2'b00);
        end
        rsp_ready = 1'b1;
        #1;
        chk({tag, ".hs_rdy"}, {req_ready1, req_ready0}, 2'b00);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, ".rsp_done"}, rsp_valid, 1'b0);
        model_last = int'(eid);
    endtask

    typedef struct {
        logic        v0, v1;
        logic [3:0]  op0, op1;
        logic        sm0, sm1;
        logic [31:0] a0, b0, a1, b1;
        logic        eid;
        logic [31:0] eres;
        logic        ez;
    } vec_t;

    function automatic vec_t mk(input logic v0, input logic [3:0] op0, input logic sm0,
                                input logic [31:0] a0, input logic [31:0] b0,
                                input logic v1, input logic [3:0] op1, input logic sm1,
                                input logic [31:0] a1, input logic [31:0] b1,
                                input logic eid, input logic [31:0] eres, input logic ez);
        vec_t v;
        v.v0 = v0; v.op0 = op0; v.sm0 = sm0; v.a0 = a0; v.b0 = b0;
        v.v1 = v1; v.op1 = op1; v.sm1 = sm1; v.a1 = a1; v.b1 = b1;
        v.eid = eid; v.eres = eres; v.ez = ez;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        req_valid0 = v.v0; req_op0 = v.op0; req_sftmd0 = v.sm0; req_a0 = v.a0; req_b0 = v.b0;
        req_valid1 = v.v1; req_op1 = v.op1; req_sftmd1 = v.sm1; req_a1 = v.a1; req_b1 = v.b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        vec_t v;
        int   n0, n1, w;
        logic [32:0] zr;

        vecs[0] = mk(1, 4'h0, 0, 32'd5, 32'd7,           0, 4'h0, 0, 32'd0, 32'd0,          0, 32'd12, 0);
        vecs[1] = mk(0, 4'h0, 0, 32'd0, 32'd0,           1, 4'h1, 0, 32'h1234, 32'h1234,    1, 32'd0, 1);
        vecs[2] = mk(1, 4'h2, 0, 32'hF0F0, 32'hFF00,     1, 4'h3, 0, 32'd1, 32'd2,          0, 32'hF000, 0);
        vecs[3] = mk(1, 4'h4, 0, 32'd6, 32'd3,           1, 4'h3, 0, 32'd1, 32'd2,          1, 32'd3, 0);
        vecs[4] = mk(1, 4'h4, 0, 32'd6, 32'd3,           1, 4'h1, 0, 32'd9, 32'd9,          0, 32'd5, 0);
        vecs[5] = mk(1, 4'h7, 1, 32'h80000000, 32'd4,    0, 4'h0, 0, 32'd0, 32'd0,          0, 32'hF8000000, 0);
        vecs[6] = mk(0, 4'h0, 0, 32'd0, 32'd0,           1, 4'hC, 0, 32'd7, 32'd7,          1, 32'd0, 0);
        vecs[7] = mk(1, 4'h5, 1, 32'd1, 32'd31,          0, 4'h0, 0, 32'd0, 32'd0,          0, 32'h80000000, 0);
        vecs[8] = mk(0, 4'h0, 0, 32'd0, 32'd0,           1, 4'h6, 1, 32'h80000000, 32'd31,  1, 32'd1, 0);
        vecs[9] = mk(1, 4'h1, 0, 32'd3, 32'd5,           0, 4'h0, 0, 32'd0, 32'd0,          0, 32'hFFFFFFFE, 0);

        rst_n = 1'b0;
        rsp_ready = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (3) @(posedge clk);
        #1;
        chk("reset.rsp", {rsp_valid, rsp_id, rsp_zero, rsp_result}, 35'd0);
        chk("reset.alu", {alu_op, alu_sftmd, alu_a, alu_b}, 69'd0);
        chk("reset.rdy", {req_ready1, req_ready0}, 2'b00);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            v = vecs[i];
            drive(v);
            txn(v.eid, v.eid ? v.a1 : v.a0, v.eres, v.ez, i % 3, $sformatf("vec%0d", i));
            req_valid0 = 1'b0;
            req_valid1 = 1'b0;
        end

        // Contention: both always valid, each holds its request until granted.
        n0 = 0; n1 = 0;
        req_op0 = 4'h0; req_sftmd0 = 1'b0; req_b0 = 32'd0;
        req_op1 = 4'h0; req_sftmd1 = 1'b0; req_b1 = 32'd0;
        for (int k = 0; k < 8; k++) begin
            req_valid0 = (n0 < 4); req_a0 = 32'(n0);
            req_valid1 = (n1 < 4); req_a1 = 32'(100 + n1);
            w = (req_valid0 && req_valid1) ? 1 - model_last : (req_valid0 ? 0 : 1);
            if (w == 1) begin
                txn(1'b1, 32'(100 + n1), 32'(100 + n1), 1'b0, k % 2, $sformatf("cont%0d", k));
                n1++;
            end else begin
                txn(1'b0, 32'(n0), 32'(n0), 1'b0, k % 2, $sformatf("cont%0d", k));
                n0++;
            end
        end
        chk("cont.count", {n0[7:0], n1[7:0]}, {8'd4, 8'd4});
        req_valid0 = 1'b0; req_valid1 = 1'b0;

        // Backpressure with the other requester waiting: nothing accepted in RESP.
        drive(mk(1, 4'h0, 0, 32'd40, 32'd2, 1, 4'h2, 0, 32'hFF, 32'h0F, 0, 0, 0));
        w = 1 - model_last;
        zr = alu_fn(w ? 4'h2 : 4'h0, 1'b0, w ? 32'hFF : 32'd40, w ? 32'h0F : 32'd2);
        txn(w[0], w ? 32'hFF : 32'd40, zr[31:0], zr[32], 5, "bp");
        req_valid0 = 1'b0; req_valid1 = 1'b0;

        // Reset during RESP drops the response; last_grant returns to 1.
        drive(mk(1, 4'h7, 1, 32'h80000000, 32'd4, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        req_valid0 = 1'b0;
        @(posedge clk); #1;
        chk("rstresp.pre", {rsp_valid, rsp_result}, {1'b1, 32'hF8000000});
        rst_n = 1'b0;
        #1;
        chk("rstresp.rsp", {rsp_valid, rsp_id, rsp_zero, rsp_result}, 35'd0);
        chk("rstresp.rdy", {req_ready1, req_ready0}, 2'b00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_last = 1;
        @(posedge clk); #1;
        chk("rstresp.after", rsp_valid, 1'b0);

        // Reset during ISSUE clears the ALU drive and yields no response.
        drive(mk(0, 0, 0, 0, 0, 1, 4'h0, 0, 32'd77, 32'd1, 0, 0, 0));
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        chk("rstiss.pre", alu_a, 32'd77);
        rst_n = 1'b0;
        #1;
        chk("rstiss.alu", {alu_op, alu_sftmd, alu_a, alu_b}, 69'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_last = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rstiss.after", rsp_valid, 1'b0);

        // After reset req 0 wins the first tie.
        drive(mk(1, 4'h0, 0, 32'd1, 32'd1, 1, 4'h0, 0, 32'd2, 32'd2, 0, 0, 0));
        txn(1'b0, 32'd1, 32'd2, 1'b0, 0, "tie_after_rst");
        req_valid0 = 1'b0; req_valid1 = 1'b0;

        // Randomized traffic against the model.
        for (int k = 0; k < 40; k++) begin
            v.v0 = ($urandom_range(0, 3) != 0);
            v.v1 = ($urandom_range(0, 3) != 0);
            v.op0 = 4'($urandom_range(0, 9)); v.sm0 = (v.op0 >= 4'd5 && v.op0 <= 4'd7);
            v.op1 = 4'($urandom_range(0, 9)); v.sm1 = (v.op1 >= 4'd5 && v.op1 <= 4'd7);
            v.a0 = $urandom; v.b0 = ($urandom_range(0, 3) == 0) ? v.a0 : $urandom;
            v.a1 = $urandom; v.b1 = ($urandom_range(0, 3) == 0) ? v.a1 : $urandom;
            drive(v);
            if (!v.v0 && !v.v1) begin
                #1;
                chk($sformatf("rnd%0d.idle_rdy", k), {req_ready1, req_ready0}, 2'b00);
                @(posedge clk); #1;
                chk($sformatf("rnd%0d.idle_vld", k), rsp_valid, 1'b0);
            end else begin
                w = (v.v0 && v.v1) ? 1 - model_last : (v.v0 ? 0 : 1);
                zr = w ? alu_fn(v.op1, v.sm1, v.a1, v.b1) : alu_fn(v.op0, v.sm0, v.a0, v.b0);
                txn(w[0], w ? v.a1 : v.a0, zr[31:0], zr[32], int'($urandom_range(0, 3)),
                    $sformatf("rnd%0d", k));
            end
            req_valid0 = 1'b0;
            req_valid1 = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
